regbank_cmd_ctrl: RTL and testbench

- Command-side initiator for the `register_bank` port set.
- Accepts READ, WRITE, SWAP and FILL commands over a valid/ready handshake.
- Sequences `regwrite`, `swap`, `ra1`, `ra2`, `wa` and `wd` into the bank, captures `rd1`/`rd2`, and returns one response per command over a second valid/ready handshake.
- Sits between the test/debug host or loader and the register bank.

---
 rtl/regbank_cmd_ctrl_if.sv | 41 ++++
 rtl/regbank_cmd_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_regbank_cmd_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regbank_cmd_ctrl_if.sv
// Signal bundle between a command host, regbank_cmd_ctrl and the register bank.
// master = host/bank side, slave = the controller.
interface regbank_cmd_ctrl_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_a;
    logic [AW-1:0] cmd_b;
    logic [DW-1:0] cmd_data;

    logic          resp_valid;
    logic          resp_ready;
    logic [1:0]    resp_op;
    logic          resp_err;
    logic [DW-1:0] resp_d1;
    logic [DW-1:0] resp_d2;

    logic          rb_regwrite;
    logic          rb_swap;
    logic [AW-1:0] rb_ra1;
    logic [AW-1:0] rb_ra2;
    logic [AW-1:0] rb_wa;
    logic [DW-1:0] rb_wd;
    logic [DW-1:0] rb_rd1;
    logic [DW-1:0] rb_rd2;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_data, resp_ready, rb_rd1, rb_rd2,
        input  cmd_ready, resp_valid, resp_op, resp_err, resp_d1, resp_d2,
               rb_regwrite, rb_swap, rb_ra1, rb_ra2, rb_wa, rb_wd
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_data, resp_ready, rb_rd1, rb_rd2,
        output cmd_ready, resp_valid, resp_op, resp_err, resp_d1, resp_d2,
               rb_regwrite, rb_swap, rb_ra1, rb_ra2, rb_wa, rb_wd
    );
endinterface

// File: rtl/regbank_cmd_ctrl.sv
// Sequences READ/WRITE/SWAP/FILL commands into a register bank, one response per command.
// Define REGBANK_ZERO_PROTECT_EN to make register 0 write-protected.
module regbank_cmd_ctrl #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    regbank_cmd_ctrl_if.slave bus
);

`ifdef REGBANK_ZERO_PROTECT_EN
    localparam bit ZeroProtect = 1'b1;
`else
    localparam bit ZeroProtect = 1'b0;
`endif

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;

    typedef enum logic [1:0] {IDLE, EXEC, FILL, RESP} state_e;

    state_e        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] a_q, a_d;
    logic [AW-1:0] b_q, b_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          cmd_ready_q, cmd_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic [1:0]    resp_op_q, resp_op_d;
    logic          resp_err_q, resp_err_d;
    logic [DW-1:0] resp_d1_q, resp_d1_d;
    logic [DW-1:0] resp_d2_q, resp_d2_d;
    logic          rb_regwrite_q, rb_regwrite_d;
    logic          rb_swap_q, rb_swap_d;
    logic [AW-1:0] rb_ra1_q, rb_ra1_d;
    logic [AW-1:0] rb_ra2_q, rb_ra2_d;
    logic [AW-1:0] rb_wa_q, rb_wa_d;
    logic [DW-1:0] rb_wd_q, rb_wd_d;

    function automatic logic isProtected(input logic [AW-1:0] addr);
        return ZeroProtect && (addr == '0);
    endfunction

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_op     = resp_op_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.resp_d1     = resp_d1_q;
    assign bus.resp_d2     = resp_d2_q;
    assign bus.rb_regwrite = rb_regwrite_q;
    assign bus.rb_swap     = rb_swap_q;
    assign bus.rb_ra1      = rb_ra1_q;
    assign bus.rb_ra2      = rb_ra2_q;
    assign bus.rb_wa       = rb_wa_q;
    assign bus.rb_wd       = rb_wd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            cmd_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_op_q     <= '0;
            resp_err_q    <= 1'b0;
            resp_d1_q     <= '0;
            resp_d2_q     <= '0;
            rb_regwrite_q <= 1'b0;
            rb_swap_q     <= 1'b0;
            rb_ra1_q      <= '0;
            rb_ra2_q      <= '0;
            rb_wa_q       <= '0;
            rb_wd_q       <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            cmd_ready_q   <= cmd_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_op_q     <= resp_op_d;
            resp_err_q    <= resp_err_d;
            resp_d1_q     <= resp_d1_d;
            resp_d2_q     <= resp_d2_d;
            rb_regwrite_q <= rb_regwrite_d;
            rb_swap_q     <= rb_swap_d;
            rb_ra1_q      <= rb_ra1_d;
            rb_ra2_q      <= rb_ra2_d;
            rb_wa_q       <= rb_wa_d;
            rb_wd_q       <= rb_wd_d;
        end
    end

    // Bank strobes are computed one cycle ahead so they leave flops during EXEC/FILL.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        cmd_ready_d   = cmd_ready_q;
        resp_valid_d  = resp_valid_q;
        resp_op_d     = resp_op_q;
        resp_err_d    = resp_err_q;
        resp_d1_d     = resp_d1_q;
        resp_d2_d     = resp_d2_q;
        rb_regwrite_d = 1'b0;
        rb_swap_d     = 1'b0;
        rb_ra1_d      = rb_ra1_q;
        rb_ra2_d      = rb_ra2_q;
        rb_wa_d       = rb_wa_q;
        rb_wd_d       = rb_wd_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    op_d        = bus.cmd_op;
                    a_d         = bus.cmd_a;
                    b_d         = bus.cmd_b;
                    err_d       = 1'b0;
                    cmd_ready_d = 1'b0;
                    state_d     = EXEC;
                    case (bus.cmd_op)
                        OP_READ: begin
                            rb_ra1_d = bus.cmd_a;
                            rb_ra2_d = bus.cmd_b;
                        end
                        OP_WRITE: begin
                            rb_wa_d       = bus.cmd_a;
                            rb_wd_d       = bus.cmd_data;
                            rb_regwrite_d = !isProtected(bus.cmd_a);
                            err_d         = isProtected(bus.cmd_a);
                        end
                        OP_SWAP: begin
                            rb_ra1_d = bus.cmd_a;
                            rb_ra2_d = bus.cmd_b;
                            if (isProtected(bus.cmd_a) || isProtected(bus.cmd_b)) begin
                                err_d = 1'b1;
                            end else begin
                                rb_swap_d = (bus.cmd_a != bus.cmd_b);
                            end
                        end
                        default: begin
                            state_d = FILL;
                            rb_wd_d = bus.cmd_data;
                            if (bus.cmd_a > bus.cmd_b) begin
                                err_d = 1'b1;
                            end else begin
                                cnt_d         = bus.cmd_a;
                                rb_wa_d       = bus.cmd_a;
                                rb_regwrite_d = !isProtected(bus.cmd_a);
                                err_d         = isProtected(bus.cmd_a);
                            end
                        end
                    endcase
                end
            end

            EXEC: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_op_d    = op_q;
                resp_err_d   = err_q;
                resp_d1_d    = (op_q == OP_READ) ? bus.rb_rd1 : '0;
                resp_d2_d    = (op_q == OP_READ) ? bus.rb_rd2 : '0;
            end

            FILL: begin
                // An inverted range never wrote anything; otherwise stop once b is written.
                if ((a_q > b_q) || (cnt_q == b_q)) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_op_d    = op_q;
                    resp_err_d   = err_q;
                    resp_d1_d    = '0;
                    resp_d2_d    = '0;
                end else begin
                    cnt_d         = cnt_q + AW'(1);
                    rb_wa_d       = cnt_d;
                    rb_regwrite_d = !isProtected(cnt_d);
                    if (isProtected(cnt_d)) begin
                        err_d = 1'b1;
                    end
                end
            end

            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    cmd_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regbank_cmd_ctrl.sv
// Bench for regbank_cmd_ctrl: directed and random commands scored against a register-file
// reference model; a bank model answers on the rb_* side.
module tb_regbank_cmd_ctrl;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int Depth = 1 << AW;

`ifdef REGBANK_ZERO_PROTECT_EN
    localparam bit ZeroProtect = 1'b1;
`else
    localparam bit ZeroProtect = 1'b0;
`endif

    typedef struct {
        logic [1:0]    op;
        logic          err;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        int            nWr;
        int            nSw;
        int            lat;
    } expect_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic loadBank = 1'b1;
    int   cycleCnt = 0;
    int   checks = 0;
    int   failures = 0;
    int   readyMode = 0;

    logic [DW-1:0] bank   [Depth];
    logic [DW-1:0] refMem [Depth];
    expect_t       expQ   [$];

    always #5 clk = ~clk;

    regbank_cmd_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    regbank_cmd_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.rb_rd1 = bank[bus.rb_ra1];
    assign bus.rb_rd2 = bank[bus.rb_ra2];

    // Register bank model; keeps its contents across controller resets.
    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
        if (loadBank) begin
            for (int i = 0; i < Depth; i++) bank[i] <= refMem[i];
        end else if (bus.rb_regwrite) begin
            bank[bus.rb_wa] <= bus.rb_wd;
        end else if (bus.rb_swap) begin
            bank[bus.rb_ra1] <= bank[bus.rb_ra2];
            bank[bus.rb_ra2] <= bank[bus.rb_ra1];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: what the command means to the register file.
    task automatic modelCommand(input logic [1:0] op, input int a, input int b,
                                input logic [DW-1:0] data, output expect_t e);
        logic [DW-1:0] tmp;
        e.op = op; e.err = 1'b0; e.d1 = '0; e.d2 = '0; e.nWr = 0; e.nSw = 0; e.lat = 1;
        case (op)
            2'd0: begin
                e.d1 = refMem[a];
                e.d2 = refMem[b];
            end
            2'd1: begin
                if (ZeroProtect && a == 0) e.err = 1'b1;
                else begin refMem[a] = data; e.nWr = 1; end
            end
            2'd2: begin
                if (ZeroProtect && (a == 0 || b == 0)) e.err = 1'b1;
                else if (a != b) begin
                    tmp = refMem[a]; refMem[a] = refMem[b]; refMem[b] = tmp; e.nSw = 1;
                end
            end
            default: begin
                if (a > b) e.err = 1'b1;
                else begin
                    e.lat = b - a + 1;
                    for (int i = a; i <= b; i++) begin
                        if (ZeroProtect && i == 0) e.err = 1'b1;
                        else begin refMem[i] = data; e.nWr++; end
                    end
                end
            end
        endcase
    endtask

    task automatic applyStimulus(input logic [1:0] op, input int a, input int b,
                                 input logic [DW-1:0] data);
        expect_t e;
        int waitCyc = 0;
        @(posedge clk); #1;
        while (!bus.cmd_ready) begin
            if (waitCyc == 300) begin
                checkOutput("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
                return;
            end
            waitCyc++;
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = AW'(a);
        bus.cmd_b     = AW'(b);
        bus.cmd_data  = data;
        modelCommand(op, a, b, data, e);
        expQ.push_back(e);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom_range(0, 3));
        bus.cmd_a     = AW'($urandom_range(0, Depth - 1));
        bus.cmd_b     = AW'($urandom_range(0, Depth - 1));
        bus.cmd_data  = $urandom;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((expQ.size() != 0 || bus.resp_valid) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drain", 32'(expQ.size()), 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " cmd_ready"},   32'(bus.cmd_ready), 32'd1);
        checkOutput({tag, " resp_valid"},  32'(bus.resp_valid), 32'd0);
        checkOutput({tag, " resp_op"},     32'(bus.resp_op), 32'd0);
        checkOutput({tag, " resp_err"},    32'(bus.resp_err), 32'd0);
        checkOutput({tag, " resp_d1"},     bus.resp_d1, 32'd0);
        checkOutput({tag, " resp_d2"},     bus.resp_d2, 32'd0);
        checkOutput({tag, " rb_regwrite"}, 32'(bus.rb_regwrite), 32'd0);
        checkOutput({tag, " rb_swap"},     32'(bus.rb_swap), 32'd0);
        checkOutput({tag, " rb_ra1"},      32'(bus.rb_ra1), 32'd0);
        checkOutput({tag, " rb_ra2"},      32'(bus.rb_ra2), 32'd0);
        checkOutput({tag, " rb_wa"},       32'(bus.rb_wa), 32'd0);
        checkOutput({tag, " rb_wd"},       bus.rb_wd, 32'd0);
    endtask

    // Response consumer: random back-pressure unless a test holds it off.
    initial begin
        bus.resp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.resp_ready = (readyMode == 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
        end
    end

    // Monitor: counts bank strobes and latency per command, scores each retired response.
    initial begin : monitor
        int busy = 0, respSeen = 0, held = 0;
        int acceptCycle = 0, wrCnt = 0, swCnt = 0, lat = 0;
        logic [1:0]    hOp;
        logic          hErr;
        logic [DW-1:0] hD1, hD2;
        expect_t       e;
        hOp = '0; hErr = 1'b0; hD1 = '0; hD2 = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 0; respSeen = 0; held = 0;
            end else begin
                if (busy != 0) begin
                    wrCnt += int'(bus.rb_regwrite);
                    swCnt += int'(bus.rb_swap);
                end
                if (bus.resp_valid) begin
                    checkOutput("cmd_ready_while_resp", 32'(bus.cmd_ready), 32'd0);
                    if (respSeen == 0) begin
                        respSeen = 1;
                        lat = cycleCnt - acceptCycle;
                    end
                    if (held != 0) begin
                        checkOutput("stable resp_op",  32'(bus.resp_op), 32'(hOp));
                        checkOutput("stable resp_err", 32'(bus.resp_err), 32'(hErr));
                        checkOutput("stable resp_d1",  bus.resp_d1, hD1);
                        checkOutput("stable resp_d2",  bus.resp_d2, hD2);
                    end
                    if (bus.resp_ready) begin
                        if (expQ.size() == 0) begin
                            checkOutput("unexpected_resp", 32'(bus.resp_valid), 32'd0);
                        end else begin
                            e = expQ.pop_front();
                            checkOutput("resp_op",  32'(bus.resp_op), 32'(e.op));
                            checkOutput("resp_err", 32'(bus.resp_err), 32'(e.err));
                            checkOutput("resp_d1",  bus.resp_d1, e.d1);
                            checkOutput("resp_d2",  bus.resp_d2, e.d2);
                            checkOutput("regwrite_cycles", wrCnt, e.nWr);
                            checkOutput("swap_cycles", swCnt, e.nSw);
                            checkOutput("latency", lat, e.lat);
                        end
                        busy = 0; respSeen = 0; held = 0;
                    end else begin
                        held = 1;
                        hOp = bus.resp_op; hErr = bus.resp_err; hD1 = bus.resp_d1; hD2 = bus.resp_d2;
                    end
                end
                if (bus.cmd_valid && bus.cmd_ready) begin
                    busy = 1; respSeen = 0; held = 0;
                    acceptCycle = cycleCnt + 1;
                    wrCnt = 0; swCnt = 0;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] old0, old1, fillData;
        expect_t e;
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_data  = '0;
        for (int i = 0; i < Depth; i++) refMem[i] = $urandom;

        repeat (3) @(posedge clk);
        #1 loadBank = 1'b0;
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk); #1 rst = 1'b0;

        $display("[TB] directed command sequence");
        applyStimulus(2'd1, 3, 3, 32'hDEADBEEF);
        applyStimulus(2'd0, 3, 3, 32'h0);
        applyStimulus(2'd1, 5, 5, 32'h11);
        applyStimulus(2'd1, 9, 9, 32'h22);
        applyStimulus(2'd2, 5, 9, 32'h0);
        applyStimulus(2'd0, 5, 9, 32'h0);
        applyStimulus(2'd2, 7, 7, 32'h0);
        applyStimulus(2'd3, 10, 13, 32'hA5A5A5A5);
        applyStimulus(2'd0, 10, 13, 32'h0);
        applyStimulus(2'd0, 9, 14, 32'h0);
        applyStimulus(2'd3, 31, 31, 32'h5A5A0001);
        applyStimulus(2'd0, 31, 30, 32'h0);
        applyStimulus(2'd3, 6, 2, 32'h12345678);
        applyStimulus(2'd1, 0, 0, 32'hCAFEF00D);
        applyStimulus(2'd0, 0, 1, 32'h0);
        waitDrain();

        $display("[TB] random commands");
        for (int k = 0; k < 200; k++) begin
            applyStimulus(2'($urandom_range(0, 3)), int'($urandom_range(0, Depth - 1)),
                          int'($urandom_range(0, Depth - 1)), $urandom);
        end
        waitDrain();

        $display("[TB] response back-pressure");
        readyMode = 1;
        applyStimulus(2'd0, 10, 3, 32'h0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("bp resp_valid", 32'(bus.resp_valid), 32'd1);
        checkOutput("bp cmd_ready", 32'(bus.cmd_ready), 32'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd1;
        bus.cmd_a     = AW'(12);
        bus.cmd_b     = AW'(1);
        bus.cmd_data  = 32'h0BADF00D;
        modelCommand(2'd1, 12, 1, 32'h0BADF00D, e);
        expQ.push_back(e);
        repeat (3) @(posedge clk);
        #1 readyMode = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cmd_ready && n < 200);
        checkOutput("bp accept after handshake", 32'(bus.resp_valid), 32'd0);
        @(posedge clk); #1 bus.cmd_valid = 1'b0;
        applyStimulus(2'd0, 12, 12, 32'h0);
        waitDrain();

        $display("[TB] reset during FILL");
        old0 = refMem[0];
        old1 = refMem[1];
        fillData = 32'h600DCAFE;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd3;
        bus.cmd_a     = AW'(0);
        bus.cmd_b     = AW'(31);
        bus.cmd_data  = fillData;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkResetOutputs("mid-fill reset");
        checkOutput("mid-fill r0", bank[0], ZeroProtect ? old0 : fillData);
        checkOutput("mid-fill r1", bank[1], old1);
        if (!ZeroProtect) refMem[0] = fillData;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("post-reset resp_valid", 32'(bus.resp_valid), 32'd0);
        end

        $display("[TB] final register sweep");
        for (int r = 0; r < Depth; r += 2) applyStimulus(2'd0, r, r + 1, 32'h0);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
